// File: rtl/pipe_skid_stage.sv
// Two-entry skid buffer between decode and execute, with flush, hold and a bubble fill when empty.
// Optional PIPE_SKID_PERF_EN adds a saturating bubble_cnt output counting cycles without a valid head.
module pipe_skid_stage #(
    parameter int                PC_W      = 32,
    parameter int                INSN_W    = 32,
    parameter int                PAYLOAD_W = 128,
    parameter int                CTRL_W    = 32,
    parameter logic [INSN_W-1:0] NOP_INSN  = 32'h6800_0000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PC_W-1:0]      in_pc,
    input  logic [INSN_W-1:0]    in_insn,
    input  logic [PAYLOAD_W-1:0] in_payload,
    input  logic [CTRL_W-1:0]    in_ctrl,
    input  logic                 flush,
    input  logic                 hold,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PC_W-1:0]      out_pc,
    output logic [INSN_W-1:0]    out_insn,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [CTRL_W-1:0]    out_ctrl,
    output logic [1:0]           occupancy
`ifdef PIPE_SKID_PERF_EN
    ,
    output logic [15:0]          bubble_cnt
`endif
);

    // state | meaning
    // EMPTY | no entry held, head registers carry the bubble
    // ONE   | head slot valid
    // TWO   | head and skid slots valid, upstream back-pressured
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    typedef struct packed {
        logic [PC_W-1:0]      pc;
        logic [INSN_W-1:0]    insn;
        logic [PAYLOAD_W-1:0] payload;
        logic [CTRL_W-1:0]    ctrl;
    } entry_t;

    localparam entry_t BUBBLE = '{pc: '0, insn: NOP_INSN, payload: '0, ctrl: '0};

    state_t r_state;
    entry_t r_head;
    entry_t r_skid;
    logic   r_rdy_en;

    state_t w_state_nxt;
    entry_t w_head_nxt;
    entry_t w_skid_nxt;
    entry_t w_in_entry;
    logic   w_push;
    logic   w_pop;

    // r_rdy_en keeps in_ready low until the first edge after reset is released.
    assign in_ready  = r_rdy_en & (r_state != TWO) & ~hold & ~flush;
    assign out_valid = (r_state != EMPTY) & ~hold & ~flush;
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;

    assign w_in_entry = '{pc: in_pc, insn: in_insn, payload: in_payload, ctrl: in_ctrl};

    assign out_pc      = r_head.pc;
    assign out_insn    = r_head.insn;
    assign out_payload = r_head.payload;
    assign out_ctrl    = r_head.ctrl;
    assign occupancy   = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= EMPTY;
            r_head   <= BUBBLE;
            r_skid   <= BUBBLE;
            r_rdy_en <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_head   <= w_head_nxt;
            r_skid   <= w_skid_nxt;
            r_rdy_en <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_head_nxt  = r_head;
        w_skid_nxt  = r_skid;
        if (flush) begin
            w_state_nxt = EMPTY;
            w_head_nxt  = BUBBLE;
            w_skid_nxt  = BUBBLE;
        end else if (!hold) begin
            unique case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        w_state_nxt = ONE;
                        w_head_nxt  = w_in_entry;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        w_state_nxt = TWO;
                        w_skid_nxt  = w_in_entry;
                    end else if (w_pop && !w_push) begin
                        w_state_nxt = EMPTY;
                        w_head_nxt  = BUBBLE;
                    end else if (w_push && w_pop) begin
                        w_head_nxt  = w_in_entry;
                    end
                end
                TWO: begin
                    if (w_pop) begin
                        w_state_nxt = ONE;
                        w_head_nxt  = r_skid;
                        w_skid_nxt  = BUBBLE;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                    w_head_nxt  = BUBBLE;
                    w_skid_nxt  = BUBBLE;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_PERF_EN
    logic [15:0] r_bubble_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bubble_cnt <= 16'h0000;
        end else if (!out_valid && (r_bubble_cnt != 16'hFFFF)) begin
            r_bubble_cnt <= r_bubble_cnt + 16'h0001;
        end
    end

    assign bubble_cnt = r_bubble_cnt;
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Scoreboard bench for pipe_skid_stage: accepted entries are queued, a monitor checks them on pop.
// An occupancy model also checks the handshake outputs and the bubble fill every cycle.
module tb_pipe_skid_stage;
    localparam logic [31:0] NOP = 32'h6800_0000;

    typedef struct packed {
        logic [31:0]  pc;
        logic [31:0]  insn;
        logic [127:0] payload;
        logic [31:0]  ctrl;
    } ent_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pc;
    logic [31:0]  in_insn;
    logic [127:0] in_payload;
    logic [31:0]  in_ctrl;
    logic         flush;
    logic         hold;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_pc;
    logic [31:0]  out_insn;
    logic [127:0] out_payload;
    logic [31:0]  out_ctrl;
    logic [1:0]   occupancy;
`ifdef PIPE_SKID_PERF_EN
    logic [15:0]  bubble_cnt;
`endif

    int   checks   = 0;
    int   failures = 0;
    ent_t exp_q[$];
    int   m_occ    = 0;
    bit   m_rdy    = 1'b0;

    pipe_skid_stage dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_pc      (in_pc),
        .in_insn    (in_insn),
        .in_payload (in_payload),
        .in_ctrl    (in_ctrl),
        .flush      (flush),
        .hold       (hold),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_insn   (out_insn),
        .out_payload(out_payload),
        .out_ctrl   (out_ctrl),
        .occupancy  (occupancy)
`ifdef PIPE_SKID_PERF_EN
        ,
        .bubble_cnt (bubble_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [31:0] pc);
        ent_t e;
        e.pc      = pc;
        e.insn    = pc + 32'h1000;
        e.payload = {4{pc ^ 32'hDEAD_0000}};
        e.ctrl    = ~pc;
        return e;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [255:0] head_bits();
        return {32'b0, out_pc, out_insn, out_payload, out_ctrl};
    endfunction

    task automatic cyc(input bit v, input logic [31:0] pc, input bit ordy, input bit h, input bit f);
        ent_t e;
        @(posedge clk);
        #1;
        e          = mk(pc);
        in_valid   = v;
        in_pc      = e.pc;
        in_insn    = e.insn;
        in_payload = e.payload;
        in_ctrl    = e.ctrl;
        out_ready  = ordy;
        hold       = h;
        flush      = f;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
        check({tag, "_in_ready"}, 256'(in_ready), 256'(0));
        check({tag, "_occupancy"}, 256'(occupancy), 256'(0));
        check({tag, "_bubble"}, head_bits(), {32'b0, 32'b0, NOP, 128'b0, 32'b0});
    endtask

    // Occupancy model: checks handshake decode and records accepted entries.
    always @(negedge clk) begin
        bit e_ir, e_ov, push, pop;
        if (rst) begin
            m_occ = 0;
            m_rdy = 1'b0;
            exp_q.delete();
        end else begin
            e_ir = m_rdy && (m_occ != 2) && !hold && !flush;
            e_ov = (m_occ != 0) && !hold && !flush;
            check("in_ready", 256'(in_ready), 256'(e_ir));
            check("out_valid", 256'(out_valid), 256'(e_ov));
            check("occupancy", 256'(occupancy), 256'(m_occ));
            if (m_occ == 0)
                check("bubble_head", head_bits(), {32'b0, 32'b0, NOP, 128'b0, 32'b0});
            push = in_valid && e_ir;
            pop  = e_ov && out_ready;
            if (flush) begin
                exp_q.delete();
                m_occ = 0;
            end else begin
                if (push) exp_q.push_back(ent_t'({in_pc, in_insn, in_payload, in_ctrl}));
                m_occ = m_occ + int'(push) - int'(pop);
            end
            m_rdy = 1'b1;
        end
    end

    // Monitor: every entry the DUT hands downstream must be the oldest expected one.
    always @(negedge clk) begin
        ent_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual_pc=%0h required=no_entry t=%0t", out_pc, $time);
            end else begin
                e = exp_q.pop_front();
                check("out_entry", head_bits(), {32'b0, e});
            end
        end
    end

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_pc      = '0;
        in_insn    = '0;
        in_payload = '0;
        in_ctrl    = '0;
        flush      = 1'b0;
        hold       = 1'b0;
        out_ready  = 1'b0;
        #2;
        check_reset_state("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 32'h0, 1, 0, 0);

        // single push, 1-cycle latency
        cyc(1, 32'h10, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // fill to two with downstream stalled, third push refused, then drain in order
        cyc(1, 32'h24, 0, 0, 0);
        cyc(1, 32'h28, 0, 0, 0);
        cyc(1, 32'h2C, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // simultaneous push and pop with one held
        cyc(1, 32'h30, 0, 0, 0);
        cyc(1, 32'h34, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // flush while full, with a valid input in the flush cycle
        cyc(1, 32'h40, 0, 0, 0);
        cyc(1, 32'h44, 0, 0, 0);
        cyc(1, 32'h18, 0, 0, 1);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // hold for three cycles, head re-presented afterwards
        cyc(1, 32'h20, 0, 0, 0);
        cyc(1, 32'h99, 1, 1, 0);
        cyc(1, 32'h99, 1, 1, 0);
        cyc(1, 32'h99, 1, 1, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

        // asynchronous reset between edges while full
        cyc(1, 32'h50, 0, 0, 0);
        cyc(1, 32'h54, 0, 0, 0);
        cyc(0, 32'h0, 0, 0, 0);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1 rst = 1'b0;
        cyc(0, 32'h0, 1, 0, 0);
        cyc(1, 32'h60, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);
        cyc(0, 32'h0, 1, 0, 0);

`ifdef PIPE_SKID_PERF_EN
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("bubble_cnt_5", 256'(bubble_cnt), 256'(5));
        repeat (70000) @(posedge clk);
        #1;
        check("bubble_cnt_sat", 256'(bubble_cnt), 256'(16'hFFFF));
`endif

        @(negedge clk);
        check("queue_drained", 256'(exp_q.size()), 256'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
